// File: rtl/rx_seq_pkg.sv
// rtl/rx_seq_pkg.sv - shared state encoding and default timing for the 8N1 receive sequencer
package rx_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START_CHK,
    RECV,
    STOP_CHK,
    LOAD
  } rx_state_t;

  localparam int unsigned DEF_CLKS_PER_BIT = 10;
  localparam int unsigned DEF_NUM_BITS     = 9;

endpackage

// File: rtl/bit_period_timer.sv
// rtl/bit_period_timer.sv - clearable up-counter that wraps from the rollover value back to 1
module bit_period_timer #(
  parameter int unsigned MAX_VAL = 10,
  parameter int unsigned W       = $clog2(MAX_VAL + 1)
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         clear_i,
  input  logic         enable_i,
  input  logic [W-1:0] rollover_val_i,
  output logic [W-1:0] count_o,
  output logic         rollover_flag_o
);

  logic [W-1:0] count_q, count_d;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // clear has priority so the FSM can restart a period in the same cycle it stops counting
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = (count_q == rollover_val_i) ? W'(1) : count_q + W'(1);
    end
  end

  assign count_o         = count_q;
  assign rollover_flag_o = (count_q == rollover_val_i);

endmodule

// File: rtl/rx_frame_sequencer.sv
// rtl/rx_frame_sequencer.sv - 8N1 receive control: start detect, mid-bit strobes, stop check, output buffer
module rx_frame_sequencer
  import rx_seq_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int unsigned NUM_BITS     = DEF_NUM_BITS
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       serial_in,
  input  logic [7:0] packet_data,
  input  logic       stop_bit,
  input  logic       data_read,
  output logic       shift_strobe,
  output logic [7:0] rx_data,
  output logic       data_ready,
  output logic       framing_error,
  output logic       overrun_error
);

  localparam int unsigned TW = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned BW = $clog2(NUM_BITS + 1);
  localparam logic [TW-1:0] T_MAX  = TW'(CLKS_PER_BIT);
  localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] B_MAX  = BW'(NUM_BITS);
  localparam logic [BW-1:0] B_LAST = BW'(NUM_BITS - 1);

  rx_state_t   state_q, state_d;
  logic        sync1_q, sync_q, prev_q;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        ready_q, ready_d;
  logic        framing_q, framing_d;
  logic        overrun_q, overrun_d;
  logic        t_clear, t_en, t_roll;
  logic        b_clear, b_en, b_roll;
  logic [TW-1:0] t_count;
  logic [BW-1:0] b_count;
  logic        strobe;
  logic        start_edge;

  bit_period_timer #(.MAX_VAL(CLKS_PER_BIT), .W(TW)) u_bit_timer (
    .clk            (clk),
    .n_rst          (n_rst),
    .clear_i        (t_clear),
    .enable_i       (t_en),
    .rollover_val_i (T_MAX),
    .count_o        (t_count),
    .rollover_flag_o(t_roll)
  );

  bit_period_timer #(.MAX_VAL(NUM_BITS), .W(BW)) u_bit_count (
    .clk            (clk),
    .n_rst          (n_rst),
    .clear_i        (b_clear),
    .enable_i       (b_en),
    .rollover_val_i (B_MAX),
    .count_o        (b_count),
    .rollover_flag_o(b_roll)
  );

  assign start_edge = prev_q & ~sync_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      sync1_q   <= 1'b1;
      sync_q    <= 1'b1;
      prev_q    <= 1'b1;
      rx_data_q <= '0;
      ready_q   <= 1'b0;
      framing_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= serial_in;
      sync_q    <= sync1_q;
      prev_q    <= sync_q;
      rx_data_q <= rx_data_d;
      ready_q   <= ready_d;
      framing_q <= framing_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    t_clear   = 1'b0;
    t_en      = 1'b0;
    b_clear   = 1'b0;
    b_en      = 1'b0;
    strobe    = 1'b0;
    rx_data_d = rx_data_q;
    ready_d   = ready_q;
    framing_d = framing_q;
    overrun_d = overrun_q;

    if (data_read && ready_q) begin
      ready_d   = 1'b0;
      overrun_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        // the edge cycle itself counts toward the half-bit wait
        t_clear = ~start_edge;
        t_en    = start_edge;
        if (start_edge) state_d = START_CHK;
      end
      START_CHK: begin
        t_en = 1'b1;
        if (t_count == T_HALF) begin
          t_clear = 1'b1;
          if (!sync_q) begin
            state_d   = RECV;
            b_clear   = 1'b1;
            framing_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      RECV: begin
        t_en = 1'b1;
        if (t_roll && !b_roll) begin
          strobe = 1'b1;
          b_en   = 1'b1;
          if (b_count == B_LAST) state_d = STOP_CHK;
        end
      end
      STOP_CHK: begin
        if (stop_bit) begin
          state_d = LOAD;
        end else begin
          framing_d = 1'b1;
          state_d   = IDLE;
        end
      end
      LOAD: begin
        rx_data_d = packet_data;
        ready_d   = 1'b1;
        overrun_d = data_read ? 1'b0 : (overrun_q | ready_q);
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign shift_strobe  = strobe;
  assign rx_data       = rx_data_q;
  assign data_ready    = ready_q;
  assign framing_error = framing_q;
  assign overrun_error = overrun_q;

endmodule
